// File: rtl/fu_pkg.sv
// Shared constants for the functional-unit write-back path: FU ids and default widths.
package fu_pkg;
  localparam int FU_ID_W    = 3;
  localparam int DEF_NUM_FU = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;

  localparam logic [FU_ID_W-1:0] FU_ALU  = 3'd0;
  localparam logic [FU_ID_W-1:0] FU_MEM  = 3'd1;
  localparam logic [FU_ID_W-1:0] FU_MUL  = 3'd2;
  localparam logic [FU_ID_W-1:0] FU_DIV  = 3'd3;
  localparam logic [FU_ID_W-1:0] FU_JUMP = 3'd4;
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational picker: first set request at or after the start pointer, wrapping modulo NUM_FU.
module wb_rr_pick
  import fu_pkg::*;
#(
  parameter int NUM_FU = DEF_NUM_FU,
  parameter int IDX_W  = FU_ID_W
) (
  input  logic [NUM_FU-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_FU-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);
  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_FU);

  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (pos >= NUM_L) pos = pos - NUM_L;
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt_o[pos[IDX_W-1:0]] = 1'b1;
        idx_o                 = pos[IDX_W-1:0];
      end
    end
    any_o = |req_i;
  end
endmodule

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: per-FU holding slots drained one per cycle onto the register-file port.
// Define WB_ARB_RR_EN for round-robin grant; default build is fixed priority (FU 0 highest).
module fu_wb_arbiter
  import fu_pkg::*;
#(
  parameter int NUM_FU = DEF_NUM_FU,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        fu_finish,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  input  logic [NUM_FU*RD_W-1:0]   fu_rd,
  input  logic                     wb_ready,
  output logic                     wb_valid,
  output logic [FU_ID_W-1:0]       wb_fu_id,
  output logic [RD_W-1:0]          wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     wb_we,
  output logic [NUM_FU-1:0]        fu_pending,
  output logic                     ovf_err
);
  logic [NUM_FU-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0]  data_q [NUM_FU];
  logic [DATA_W-1:0]  data_d [NUM_FU];
  logic [RD_W-1:0]    rd_q   [NUM_FU];
  logic [RD_W-1:0]    rd_d   [NUM_FU];
  logic               ovf_q, ovf_d;
  logic [NUM_FU-1:0]  gnt;
  logic [FU_ID_W-1:0] win, ptr;
  logic               any, xfer;

  // Grant looks only at registered pending bits, never at same-cycle finishes.
  wb_rr_pick #(.NUM_FU(NUM_FU), .IDX_W(FU_ID_W)) u_pick (
    .req_i (pend_q),
    .ptr_i (ptr),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  assign xfer = any & wb_ready;

`ifdef WB_ARB_RR_EN
  logic [FU_ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (win == FU_ID_W'(NUM_FU-1)) ? '0 : win + FU_ID_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // A slot refills only when empty or draining this cycle; otherwise the new result is lost.
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (xfer && gnt[i]) pend_d[i] = 1'b0;
      if (fu_finish[i]) begin
        if (!pend_q[i] || (xfer && gnt[i])) begin
          pend_d[i] = 1'b1;
          data_d[i] = fu_data[i*DATA_W +: DATA_W];
          rd_d[i]   = fu_rd[i*RD_W +: RD_W];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      data_q <= data_d;
      rd_q   <= rd_d;
    end
  end

  assign wb_valid   = any;
  assign wb_fu_id   = any ? win : '0;
  assign wb_rd      = any ? rd_q[win] : '0;
  assign wb_data    = any ? data_q[win] : '0;
  assign wb_we      = any & (wb_rd != '0);
  assign fu_pending = pend_q;
  assign ovf_err    = ovf_q;
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter (default fixed-priority build).
module tb_fu_wb_arbiter;
  import fu_pkg::*;

  localparam int NUM_FU = 5;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_FU-1:0]        fu_finish;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU*RD_W-1:0]   fu_rd;
  logic                     wb_ready;
  logic                     wb_valid;
  logic [FU_ID_W-1:0]       wb_fu_id;
  logic [RD_W-1:0]          wb_rd;
  logic [DATA_W-1:0]        wb_data;
  logic                     wb_we;
  logic [NUM_FU-1:0]        fu_pending;
  logic                     ovf_err;

  int checks = 0;
  int errors = 0;

  fu_wb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fu_finish  (fu_finish),
    .fu_data    (fu_data),
    .fu_rd      (fu_rd),
    .wb_ready   (wb_ready),
    .wb_valid   (wb_valid),
    .wb_fu_id   (wb_fu_id),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .fu_pending (fu_pending),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fin(input int i, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r);
    fu_finish[i]                = 1'b1;
    fu_data[i*DATA_W +: DATA_W] = d;
    fu_rd[i*RD_W +: RD_W]       = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fu_finish = '0; fu_data = '0; fu_rd = '0; wb_ready = 1'b1;
    tick(); tick();
    chk("rst_valid",   wb_valid,   0);
    chk("rst_pending", fu_pending, 0);
    chk("rst_data",    wb_data,    0);
    chk("rst_ovf",     ovf_err,    0);
    rst = 1'b0;
    tick();

    // Single JUMP result
    fin(FU_JUMP, 32'h0000_1008, 5'd1);
    tick(); fu_finish = '0;
    chk("single_valid", wb_valid, 1);
    chk("single_id",    wb_fu_id, 4);
    chk("single_data",  wb_data,  32'h1008);
    chk("single_rd",    wb_rd,    1);
    chk("single_we",    wb_we,    1);
    chk("single_pend",  fu_pending, 5'b10000);
    tick();
    chk("single_done_valid", wb_valid,   0);
    chk("single_done_pend",  fu_pending, 0);

    // Three-way collision drains 0, 2, 4
    fin(0, 32'hA000_0000, 5'd2);
    fin(2, 32'hA000_0002, 5'd3);
    fin(4, 32'hA000_0004, 5'd4);
    tick(); fu_finish = '0;
    chk("col0_id",   wb_fu_id,   0);
    chk("col0_data", wb_data,    32'hA000_0000);
    chk("col0_pend", fu_pending, 5'b10101);
    tick();
    chk("col1_id",   wb_fu_id,   2);
    chk("col1_rd",   wb_rd,      3);
    chk("col1_pend", fu_pending, 5'b10100);
    tick();
    chk("col2_id",   wb_fu_id,   4);
    chk("col2_data", wb_data,    32'hA000_0004);
    chk("col2_pend", fu_pending, 5'b10000);
    tick();
    chk("col_done", wb_valid, 0);

    // Backpressure on slot 3
    wb_ready = 1'b0;
    fin(FU_DIV, 32'h0000_33CC, 5'd7);
    tick(); fu_finish = '0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_valid", wb_valid,   1);
      chk("bp_data",  wb_data,    32'h33CC);
      chk("bp_pend",  fu_pending, 5'b01000);
      tick();
    end
    wb_ready = 1'b1;
    chk("bp_release_id", wb_fu_id, 3);
    tick();
    chk("bp_after_valid", wb_valid,   0);
    chk("bp_after_pend",  fu_pending, 0);

    // Back-to-back refill of slot 1 while it drains
    fin(FU_MEM, 32'h0000_1111, 5'd5);
    tick(); fu_finish = '0;
    chk("b2b_first", wb_data, 32'h1111);
    fin(FU_MEM, 32'h0000_2222, 5'd6);
    tick(); fu_finish = '0;
    chk("b2b_valid", wb_valid,   1);
    chk("b2b_data",  wb_data,    32'h2222);
    chk("b2b_rd",    wb_rd,      6);
    chk("b2b_pend",  fu_pending, 5'b00010);
    chk("b2b_ovf",   ovf_err,    0);
    tick();
    chk("b2b_done", wb_valid, 0);

    // Overflow: refill while pending and stalled
    wb_ready = 1'b0;
    fin(FU_MEM, 32'h0000_3333, 5'd8);
    tick(); fu_finish = '0;
    chk("ovf_pre", ovf_err, 0);
    fin(FU_MEM, 32'h0000_4444, 5'd9);
    tick(); fu_finish = '0;
    chk("ovf_data", wb_data, 32'h3333);
    chk("ovf_rd",   wb_rd,   8);
    chk("ovf_flag", ovf_err, 1);
    wb_ready = 1'b1;
    tick();
    chk("ovf_drained", wb_valid, 0);
    chk("ovf_sticky",  ovf_err,  1);

    // rd = 0 suppresses the write enable
    fin(FU_ALU, 32'h0000_BEEF, 5'd0);
    tick(); fu_finish = '0;
    chk("rd0_valid", wb_valid, 1);
    chk("rd0_we",    wb_we,    0);
    chk("rd0_data",  wb_data,  32'hBEEF);
    tick();

    // Asynchronous reset with three slots pending
    wb_ready = 1'b0;
    fin(0, 32'h0000_0010, 5'd10);
    fin(1, 32'h0000_0011, 5'd11);
    fin(2, 32'h0000_0012, 5'd12);
    tick(); fu_finish = '0;
    chk("arst_pre_pend", fu_pending, 5'b00111);
    chk("arst_pre_data", wb_data,    32'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", wb_valid,   0);
    chk("arst_pend",  fu_pending, 0);
    chk("arst_data",  wb_data,    0);
    chk("arst_id",    wb_fu_id,   0);
    chk("arst_rd",    wb_rd,      0);
    chk("arst_we",    wb_we,      0);
    chk("arst_ovf",   ovf_err,    0);
    tick();
    rst = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk("post_rst_valid", wb_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
Shares the single register-file write port among the execution units (ALU, MEM, MUL, DIV, JUMP). Each unit raises a one-cycle `finish` pulse with its result. The arbiter latches that result into a per-unit holding slot and grants one slot per cycle to the write-back bus. It sits between the FU outputs and the register file/scoreboard, and reports per-unit pending status so issue logic never re-issues a unit whose result has not yet been written back.

Parameters:
- NUM_FU, 5, number of functional units sharing write-back; index = FU id.
- DATA_W, 32, result width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fu_finish  in  NUM_FU  one-cycle completion pulse per FU.
- fu_data  in  NUM_FU*DATA_W  result per FU (JUMP supplies PC+4); slice i = bits [i*DATA_W +: DATA_W].
- fu_rd  in  NUM_FU*RD_W  destination register per FU, same slicing.
- wb_ready  in  1  register file accepts a write this cycle.
- wb_valid  out  1  a granted result is on the bus.
- wb_fu_id  out  3  id of the granted FU.
- wb_rd  out  RD_W  granted destination register.
- wb_data  out  DATA_W  granted result.
- wb_we  out  1  wb_valid & (wb_rd != 0).
- fu_pending  out  NUM_FU  slot i holds an unwritten result; issue logic must block FU i while set.
- ovf_err  out  1  sticky: a finish arrived for a slot that was already full and not being drained.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - all pending bits = 0, slot data/rd = 0, RR pointer = 0, ovf_err = 0;
  - outputs wb_valid = 0, wb_fu_id = 0, wb_rd = 0, wb_data = 0, wb_we = 0, fu_pending = 0.
- Capture: at the clk edge ending cycle N with fu_finish[i] = 1, slot i <= {fu_rd slice, fu_data slice} and pending[i] <= 1.
- Arbitration is combinational over registered pending bits only; fu_finish never feeds the grant in the same cycle.
  - Minimum latency: finish in cycle N → wb_valid in cycle N+1.
- Grant: wb_valid = |pending. The winner drives wb_fu_id/wb_rd/wb_data.
  - Fixed priority by default: lowest index wins.
  - Outputs are 0 when wb_valid = 0.
- Transfer = wb_valid & wb_ready. On transfer, pending[winner] <= 0 at the edge.
  - If wb_ready = 0, all state holds and the grant stays stable until transfer.
- Simultaneous events, slot i:
  - finish[i] while slot i is transferring → new value captured, pending[i] stays 1 (back-to-back issue supported).
  - finish[i] while pending[i] = 1 and slot i not transferring → new data dropped, old slot kept, ovf_err <= 1 (sticky until rst).
- Several finishes in one cycle are all captured; they drain one per cycle in grant order.
- fu_pending = pending register (not including same-cycle finish).
- Reset mid-operation discards all held results.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: round-robin grant. A pointer holds the index after the last transferred FU. Search starts at the pointer and wraps modulo NUM_FU. The pointer updates only on transfer; reset value is 0.
- Undefined: fixed priority, index 0 highest; no pointer register.

Decomposition:
- Package `fu_pkg`:
  - FU id constants FU_ALU=0, FU_MEM=1, FU_MUL=2, FU_DIV=3, FU_JUMP=4;
  - FU_ID_W = 3;
  - default DATA_W and RD_W.
- One sub-module, `wb_rr_pick`: combinational NUM_FU-wide request vector + start pointer → one-hot grant + encoded index. It is used with pointer tied to 0 when WB_ARB_RR_EN is undefined.

Test Plan:
- Single result: rst released; finish[4] with data 0x0000_1008, rd = 1, wb_ready = 1 → next cycle wb_valid = 1, wb_fu_id = 4, wb_data = 0x1008, wb_we = 1; following cycle wb_valid = 0, fu_pending = 0.
- Collision: finish[0], finish[2], finish[4] in the same cycle, wb_ready = 1 → fixed priority drains ids 0, 2, 4 on three consecutive cycles. With WB_ARB_RR_EN and pointer = 1, the order is 2, 4, 0.
- Backpressure: pending slot 3, wb_ready = 0 for 4 cycles → wb_valid and wb_data stable, fu_pending[3] = 1; wb_ready = 1 → one transfer, then pending clears.
- Back-to-back and overflow:
  - finish[1] in the cycle slot 1 transfers → slot 1 refilled, wb_valid again next cycle, ovf_err = 0.
  - finish[1] while slot 1 is pending and wb_ready = 0 → original data kept, ovf_err = 1.
- rd = 0: finish[0] with rd = 0 → wb_valid = 1, wb_we = 0.
- Reset: assert rst mid-cycle with 3 slots pending → outputs 0 immediately, with no clock edge needed.
